// File: rtl/spi_master_adc.sv
// SPI master that reads one 8-bit sample per frame from a serial ADC slave.
// sclk idles high; the slave shifts on falling sclk, bits are captured on rising edges 4..11.
module spi_master_adc #(
    parameter int HALF  = 2,
    parameter int QUIET = 4
) (
    input  logic       i_clk,
    input  logic       n_rst,
    input  logic       i_start,
    input  logic       i_sdata,
    output logic       o_sclk,
    output logic       o_cs_n,
    output logic [7:0] o_adc_data,
    output logic       o_data_valid,
    output logic       o_busy
);

    // state       | meaning
    // ST_IDLE     | cs_n high, waiting for start
    // ST_SETUP    | cs_n low, sclk high for HALF clks before the first falling edge
    // ST_SHIFT_LO | sclk low for HALF clks, slave shifts out the next bit
    // ST_SHIFT_HI | sclk high for HALF clks, sdata captured in the first clk
    // ST_QUIET    | cs_n high for QUIET clks between frames, still busy
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_QUIET
    } state_t;

    localparam logic [7:0] HALF_M1  = 8'(HALF - 1);
    localparam logic [7:0] QUIET_M1 = 8'(QUIET - 1);

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_cnt;
    logic [4:0]  r_edge;
    logic [7:0]  r_shift;
    logic [7:0]  r_adc_data;
    logic        r_sclk;
    logic        r_cs_n;
    logic        r_busy;
    logic        r_data_valid;
    logic        w_half_done;
    logic        w_quiet_done;
    logic        w_sample;
    logic        w_last;

    always_comb begin
        w_next       = r_state;
        w_half_done  = (r_cnt == HALF_M1);
        w_quiet_done = (r_cnt == QUIET_M1);
        w_sample     = 1'b0;
        w_last       = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (i_start) w_next = ST_SETUP;
            end
            ST_SETUP: begin
                if (w_half_done) w_next = ST_SHIFT_LO;
            end
            ST_SHIFT_LO: begin
                if (w_half_done) w_next = ST_SHIFT_HI;
            end
            ST_SHIFT_HI: begin
                // Only the data window of the 16-edge frame reaches the shift register.
                w_sample = (r_cnt == 8'd0) && (r_edge >= 5'd4) && (r_edge <= 5'd11);
                if (w_half_done) begin
                    if (r_edge == 5'd16) begin
                        w_next = ST_QUIET;
                        w_last = 1'b1;
                    end else begin
                        w_next = ST_SHIFT_LO;
                    end
                end
            end
            ST_QUIET: begin
                if (w_quiet_done) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge i_clk or negedge n_rst) begin
        if (!n_rst) begin
            r_cnt   <= 8'd0;
            r_edge  <= 5'd0;
            r_shift <= 8'd0;
        end else begin
            if ((w_next != r_state) || (r_state == ST_IDLE)) begin
                r_cnt <= 8'd0;
            end else begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (r_state == ST_IDLE) begin
                r_edge <= 5'd0;
            end else if ((r_state == ST_SHIFT_LO) && (w_next == ST_SHIFT_HI)) begin
                r_edge <= r_edge + 5'd1;
            end
            if (w_sample) begin
                r_shift <= {r_shift[6:0], i_sdata};
            end
        end
    end

    // Pin outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge i_clk or negedge n_rst) begin
        if (!n_rst) begin
            r_sclk       <= 1'b1;
            r_cs_n       <= 1'b1;
            r_busy       <= 1'b0;
            r_data_valid <= 1'b0;
            r_adc_data   <= 8'h00;
        end else begin
            r_sclk       <= (w_next != ST_SHIFT_LO);
            r_cs_n       <= (w_next == ST_IDLE) || (w_next == ST_QUIET);
            r_busy       <= (w_next != ST_IDLE);
            r_data_valid <= w_last;
            if (w_last) begin
                r_adc_data <= r_shift;
            end
        end
    end

    assign o_sclk       = r_sclk;
    assign o_cs_n       = r_cs_n;
    assign o_busy       = r_busy;
    assign o_data_valid = r_data_valid;
    assign o_adc_data   = r_adc_data;

endmodule

// File: tb/tb_spi_master_adc.sv
// Bench: two masters (HALF=2/QUIET=4 and HALF=1/QUIET=1), each paired with a serial ADC slave model.
// Frame timing and data are predicted from frame-level arithmetic, not from the master's internals.
module tb_spi_master_adc;

    localparam int HA = 2;
    localparam int QA = 4;
    localparam int HB = 1;
    localparam int QB = 1;

    logic clk = 1'b0;
    logic n_rst = 1'b1;
    logic start_a = 1'b0, start_b = 1'b0;
    logic sd_a, sd_b;
    logic sclk_a, cs_a, dv_a, busy_a, sclk_b, cs_b, dv_b, busy_b;
    logic [7:0] adc_a, adc_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    spi_master_adc #(.HALF(HA), .QUIET(QA)) u_a (
        .i_clk(clk), .n_rst(n_rst), .i_start(start_a), .i_sdata(sd_a),
        .o_sclk(sclk_a), .o_cs_n(cs_a), .o_adc_data(adc_a), .o_data_valid(dv_a), .o_busy(busy_a)
    );

    spi_master_adc #(.HALF(HB), .QUIET(QB)) u_b (
        .i_clk(clk), .n_rst(n_rst), .i_start(start_b), .i_sdata(sd_b),
        .o_sclk(sclk_b), .o_cs_n(cs_b), .o_adc_data(adc_b), .o_data_valid(dv_b), .o_busy(busy_b)
    );

    // Slave model: bit k of the frame appears after the k-th falling sclk edge.
    logic [7:0] byte_a = 8'h00, byte_b = 8'h00;
    bit xm_a = 1'b0, xm_b = 1'b0;
    int idx_a = 0, idx_b = 0;

    function automatic logic slave_bit(input logic [7:0] d, input int k, input bit xm);
        logic r;
        if (k >= 4 && k <= 11) r = d[11 - k];
        else r = xm ? 1'bx : 1'b0;
        return r;
    endfunction

    always @(negedge sclk_a or cs_a) begin
        if (cs_a) begin idx_a = 0; sd_a = 1'bz; end
        else if (!sclk_a) begin idx_a++; sd_a = slave_bit(byte_a, idx_a, xm_a); end
        else begin idx_a = 0; sd_a = xm_a ? 1'bx : 1'b0; end
    end

    always @(negedge sclk_b or cs_b) begin
        if (cs_b) begin idx_b = 0; sd_b = 1'bz; end
        else if (!sclk_b) begin idx_b++; sd_b = slave_bit(byte_b, idx_b, xm_b); end
        else begin idx_b = 0; sd_b = xm_b ? 1'bx : 1'b0; end
    end

    // Pin monitor sampled on the falling clk edge.
    logic cs_v[2], sclk_v[2], dv_v[2], busy_v[2];
    assign cs_v[0] = cs_a;     assign cs_v[1] = cs_b;
    assign sclk_v[0] = sclk_a; assign sclk_v[1] = sclk_b;
    assign dv_v[0] = dv_a;     assign dv_v[1] = dv_b;
    assign busy_v[0] = busy_a; assign busy_v[1] = busy_b;

    int lo_cnt[2] = '{0, 0}, last_lo[2] = '{0, 0}, hi_cnt[2] = '{0, 0}, last_hi[2] = '{0, 0};
    int rises[2] = '{0, 0}, since_rise[2] = '{0, 0}, last_period[2] = '{0, 0};
    int frames[2] = '{0, 0}, dvs[2] = '{0, 0};
    bit dv_at_rise[2] = '{1'b0, 1'b0};
    logic prev_cs[2] = '{1'b1, 1'b1}, prev_sclk[2] = '{1'b1, 1'b1};

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!cs_v[i]) begin
                if (prev_cs[i]) begin
                    last_hi[i] = hi_cnt[i]; hi_cnt[i] = 0; rises[i] = 0; frames[i]++;
                end
                lo_cnt[i]++;
                if (!prev_sclk[i] && sclk_v[i]) begin
                    rises[i]++; last_period[i] = since_rise[i]; since_rise[i] = 0;
                end
            end else begin
                if (!prev_cs[i]) begin
                    last_lo[i] = lo_cnt[i]; lo_cnt[i] = 0; dv_at_rise[i] = dv_v[i];
                end
                hi_cnt[i]++;
            end
            since_rise[i]++;
            if (dv_v[i]) dvs[i]++;
            prev_cs[i] = cs_v[i];
            prev_sclk[i] = sclk_v[i];
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_dv(input int i, input string tag);
        bit ok = 1'b0;
        for (int k = 0; k < 400 && !ok; k++) begin
            tick();
            ok = dv_v[i];
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    task automatic wait_idle(input int i);
        bit ok = 1'b0;
        for (int k = 0; k < 400 && !ok; k++) begin
            tick();
            ok = !busy_v[i];
        end
        chk("idle_timeout", 32'(ok), 32'd1);
    endtask

    task automatic pulse(input int i);
        if (i == 0) start_a = 1'b1; else start_b = 1'b1;
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // Frame-level expectations: a setup half-period plus 16 full sclk periods.
    function automatic int exp_lo(input int h);
        return h * (1 + 2 * 16);
    endfunction

    initial begin
        logic [7:0] d;
        int f0, d0, n, adc_moves;
        bit ok, done;

        #1 n_rst = 1'b0;
        #1;
        chk("rst_sclk", 32'(sclk_a), 32'd1);
        chk("rst_cs_n", 32'(cs_a), 32'd1);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_dv", 32'(dv_a), 32'd0);
        chk("rst_adc", 32'(adc_a), 32'd0);
        repeat (3) tick();

        // First frame: start presented together with reset release.
        byte_a = 8'hA5;
        n_rst = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("first_start_cs", 32'(cs_a), 32'd0);
        chk("first_start_busy", 32'(busy_a), 32'd1);
        wait_dv(0, "dv_timeout_a5");
        chk("a5_data", 32'(adc_a), 32'hA5);
        chk("a5_cs_low", 32'(last_lo[0]), 32'(exp_lo(HA)));
        chk("a5_rises", 32'(rises[0]), 32'd16);
        chk("a5_period", 32'(last_period[0]), 32'(2 * HA));
        chk("a5_dv_on_cs_rise", 32'(dv_at_rise[0]), 32'd1);
        tick();
        chk("a5_dv_width", 32'(dv_a), 32'd0);
        repeat (QA - 2) tick();
        chk("a5_busy_in_quiet", 32'(busy_a), 32'd1);
        tick();
        chk("a5_busy_after_quiet", 32'(busy_a), 32'd0);
        chk("a5_dv_count", 32'(dvs[0]), 32'd1);

        // Random bytes, with X on unsampled slave bits in some frames.
        for (int r = 0; r < 6; r++) begin
            wait_idle(0);
            d = 8'($urandom_range(0, 255));
            byte_a = d;
            xm_a = 1'($urandom_range(0, 1));
            pulse(0);
            wait_dv(0, "dv_timeout_rand_a");
            chk("rand_a_data", 32'(adc_a), 32'(d));
            chk("rand_a_cs_low", 32'(last_lo[0]), 32'(exp_lo(HA)));
        end
        xm_a = 1'b1;

        // Start held high: back-to-back frames.
        wait_idle(0);
        byte_a = 8'h00;
        start_a = 1'b1;
        wait_dv(0, "dv_timeout_held0");
        chk("held_first", 32'(adc_a), 32'h00);
        byte_a = 8'hFF;
        wait_dv(0, "dv_timeout_held1");
        start_a = 1'b0;
        chk("held_second", 32'(adc_a), 32'hFF);
        chk("held_gap", 32'(last_hi[0]), 32'(QA + 1));

        // Start toggling through a whole frame: one frame only, busy never drops early.
        wait_idle(0);
        d = 8'($urandom_range(0, 255));
        byte_a = d;
        f0 = frames[0];
        start_a = 1'b1;
        tick();
        n = 1;
        adc_moves = 0;
        done = 1'b0;
        for (int k = 0; k < 400 && !done; k++) begin
            start_a = ~start_a;
            tick();
            if (!cs_a && adc_a !== 8'hFF) adc_moves++;
            if (busy_a) n++;
            else done = 1'b1;
        end
        start_a = 1'b0;
        chk("spam_busy_len", 32'(n), 32'(exp_lo(HA) + QA));
        chk("spam_adc_stable", 32'(adc_moves), 32'd0);
        chk("spam_data", 32'(adc_a), 32'(d));
        repeat (10) tick();
        chk("spam_frames", 32'(frames[0] - f0), 32'd1);
        chk("spam_cs_idle", 32'(cs_a), 32'd1);

        // Reset at rising edge 7 aborts the frame.
        byte_a = 8'h3C;
        pulse(0);
        ok = 1'b0;
        for (int k = 0; k < 400 && !ok; k++) begin
            tick();
            ok = (rises[0] == 7) && !cs_a;
        end
        chk("edge7_timeout", 32'(ok), 32'd1);
        d0 = dvs[0];
        n_rst = 1'b0;
        #1;
        chk("mid_rst_cs", 32'(cs_a), 32'd1);
        chk("mid_rst_sclk", 32'(sclk_a), 32'd1);
        chk("mid_rst_adc", 32'(adc_a), 32'd0);
        chk("mid_rst_busy", 32'(busy_a), 32'd0);
        repeat (3) tick();
        chk("mid_rst_no_dv", 32'(dvs[0] - d0), 32'd0);
        n_rst = 1'b1;
        d = 8'($urandom_range(0, 255));
        byte_a = d;
        pulse(0);
        wait_dv(0, "dv_timeout_post_rst");
        chk("post_rst_data", 32'(adc_a), 32'(d));
        chk("post_rst_cs_low", 32'(last_lo[0]), 32'(exp_lo(HA)));
        chk("post_rst_rises", 32'(rises[0]), 32'd16);

        // Fastest configuration.
        wait_idle(1);
        byte_b = 8'h81;
        pulse(1);
        wait_dv(1, "dv_timeout_81");
        chk("b81_data", 32'(adc_b), 32'h81);
        chk("b81_cs_low", 32'(last_lo[1]), 32'(exp_lo(HB)));
        chk("b81_rises", 32'(rises[1]), 32'd16);
        chk("b81_period", 32'(last_period[1]), 32'(2 * HB));
        for (int r = 0; r < 4; r++) begin
            wait_idle(1);
            d = 8'($urandom_range(0, 255));
            byte_b = d;
            xm_b = 1'($urandom_range(0, 1));
            pulse(1);
            wait_dv(1, "dv_timeout_rand_b");
            chk("rand_b_data", 32'(adc_b), 32'(d));
        end
        wait_idle(1);
        start_b = 1'b1;
        wait_dv(1, "dv_timeout_held_b0");
        wait_dv(1, "dv_timeout_held_b1");
        start_b = 1'b0;
        chk("held_b_gap", 32'(last_hi[1]), 32'(QB + 1));
        wait_idle(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
